// File: rtl/arbitro_pkg.sv
// Shared types and constants for the video-memory arbiter.
package arbitro_pkg;

  // Owner of the memory port for the next cycle
  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_VID  = 2'd1,
    GNT_WR   = 2'd2
  } gnt_e;

  localparam int ARB_ADDR_W = 17;
  localparam int ARB_DATA_W = 24;

  // One buffered write at the default port widths
  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] data;
  } wr_entry_t;

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  // Saturating increment for the stall counter
  function automatic logic [15:0] stall_inc(input logic [15:0] c);
    return (c == STALL_MAX) ? c : c + 16'd1;
  endfunction

endpackage

// File: rtl/fifo_escrita.sv
// Write buffer for the arbiter: in-order FIFO of {addr, data} entries.
// Pointers wrap naturally (DEPTH is a power of two); level spans 0..DEPTH.
module fifo_escrita
  import arbitro_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 24,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty
);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              do_push, do_pop;

  assign full      = (level_q == LVL_W'(DEPTH));
  assign empty     = (level_q == '0);
  assign do_push   = push && !full && !rst;
  assign do_pop    = pop && !empty;
  assign head_addr = addr_mem[rd_ptr_q];
  assign head_data = data_mem[rd_ptr_q];
  assign level     = level_q;

  // Next-state for pointers and occupancy; push+pop leaves level unchanged
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state; reset flushes the buffer by clearing pointers and level
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Entry storage, written at the tail on each accepted push
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wr_ptr_q] <= push_addr;
      data_mem[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/arbitro_memoria_video.sv
// Single-port video-memory arbiter: VGA reads always win, game-logic writes
// are buffered in fifo_escrita and drained into free cycles.
// Optional macro ARB_VBLANK_WRITES_EN: restrict write drains to VBlank=1.
module arbitro_memoria_video
  import arbitro_pkg::*;
#(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 4,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              CLOCK_25,
  input  logic              Reset,
  input  logic              VidReq,
  input  logic [ADDR_W-1:0] VidAddr,
  output logic [DATA_W-1:0] VidData,
  output logic              VidValid,
  input  logic              WrReq,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData,
  output logic              WrAck,
  input  logic              VBlank,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWrData,
  output logic              MemWe,
  input  logic [DATA_W-1:0] MemRdData,
  output logic [LVL_W-1:0]  FifoLevel,
  output logic [15:0]       StallCount
);

  gnt_e              gnt;
  logic              pop_window;
  logic              pop, push;
  logic              fifo_full, fifo_empty;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wrdata_q;
  logic              mem_we_q;
  logic              vld_p1_q, vld_p2_q;
  logic              vid_valid_q;
  logic [DATA_W-1:0] vid_data_q;
  logic [15:0]       stall_q;

`ifdef ARB_VBLANK_WRITES_EN
  // Drain only during vertical blanking so visible frames never tear
  assign pop_window = VBlank;
`else
  logic unused_vblank;
  assign unused_vblank = VBlank;
  assign pop_window    = 1'b1;
`endif

  // Grant: VGA first, then the buffered write head, else idle
  always_comb begin
    gnt = GNT_IDLE;
    if (VidReq)                         gnt = GNT_VID;
    else if (!fifo_empty && pop_window) gnt = GNT_WR;
  end

  assign pop   = (gnt == GNT_WR);
  assign push  = WrReq && !fifo_full && !Reset;
  assign WrAck = push;

  fifo_escrita #(
    .DEPTH (FIFO_DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk      (CLOCK_25),
    .rst      (Reset),
    .push     (push),
    .pop      (pop),
    .push_addr(WrAddr),
    .push_data(WrData),
    .head_addr(head_addr),
    .head_data(head_data),
    .level    (FifoLevel),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Memory port registers: the grant of cycle N drives the RAM in cycle N+1
  always_ff @(posedge CLOCK_25) begin
    if (Reset) begin
      mem_addr_q   <= '0;
      mem_wrdata_q <= '0;
      mem_we_q     <= 1'b0;
    end else begin
      case (gnt)
        GNT_VID: begin
          mem_addr_q <= VidAddr;
          mem_we_q   <= 1'b0;
        end
        GNT_WR: begin
          mem_addr_q   <= head_addr;
          mem_wrdata_q <= head_data;
          mem_we_q     <= 1'b1;
        end
        default: mem_we_q <= 1'b0;
      endcase
    end
  end

  // Read pipeline: address at p1, RAM data at p2, registered to VGA after p2
  always_ff @(posedge CLOCK_25) begin
    if (Reset) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      vid_valid_q <= 1'b0;
      vid_data_q  <= '0;
    end else begin
      vld_p1_q    <= (gnt == GNT_VID);
      vld_p2_q    <= vld_p1_q;
      vid_valid_q <= vld_p2_q;
      if (vld_p2_q) vid_data_q <= MemRdData;
    end
  end

  // Count cycles where buffered writes exist but none drains
  always_ff @(posedge CLOCK_25) begin
    if (Reset)                  stall_q <= '0;
    else if (!fifo_empty && !pop) stall_q <= stall_inc(stall_q);
  end

  assign MemAddr    = mem_addr_q;
  assign MemWrData  = mem_wrdata_q;
  assign MemWe      = mem_we_q;
  assign VidData    = vid_data_q;
  assign VidValid   = vid_valid_q;
  assign StallCount = stall_q;

endmodule

// File: tb/tb_arbitro_memoria_video.sv
// Directed bench for arbitro_memoria_video with a 1-cycle synchronous RAM model.
module tb_arbitro_memoria_video;
  import arbitro_pkg::*;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        VidReq = 1'b0;
  logic [16:0] VidAddr = '0;
  logic [23:0] VidData;
  logic        VidValid;
  logic        WrReq = 1'b0;
  logic [16:0] WrAddr = '0;
  logic [23:0] WrData = '0;
  logic        WrAck;
  logic        VBlank = 1'b1;
  logic [16:0] MemAddr;
  logic [23:0] MemWrData;
  logic        MemWe;
  logic [23:0] MemRdData;
  logic [2:0]  FifoLevel;
  logic [15:0] StallCount;

  logic        preload = 1'b0;
  logic [23:0] mem [256];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_stall = 16'd0;

  always #5 clk = ~clk;

  arbitro_memoria_video dut (
    .CLOCK_25(clk), .Reset(Reset), .VidReq(VidReq), .VidAddr(VidAddr),
    .VidData(VidData), .VidValid(VidValid), .WrReq(WrReq), .WrAddr(WrAddr),
    .WrData(WrData), .WrAck(WrAck), .VBlank(VBlank), .MemAddr(MemAddr),
    .MemWrData(MemWrData), .MemWe(MemWe), .MemRdData(MemRdData),
    .FifoLevel(FifoLevel), .StallCount(StallCount)
  );

  // RAM model: one-cycle read latency, write on MemWe
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 24'(i);
    end else if (MemWe) begin
      mem[MemAddr[7:0]] <= MemWrData;
    end
    MemRdData <= mem[MemAddr[7:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; preload = 1'b1;
    tick();
    preload = 1'b0;
    tick();
    WrReq = 1'b1; WrAddr = 17'd3; WrData = 24'h1;
    #1;
    n_vec++; if (WrAck !== 1'b0) begin n_err++; $display("FAIL rst_wrack: got %0b want 0", WrAck); end
    WrReq = 1'b0;
    n_vec++; if (VidData !== 24'd0) begin n_err++; $display("FAIL rst_viddata: got %h want 0", VidData); end
    n_vec++; if (VidValid !== 1'b0) begin n_err++; $display("FAIL rst_vidvalid: got %0b want 0", VidValid); end
    n_vec++; if (MemAddr !== 17'd0) begin n_err++; $display("FAIL rst_memaddr: got %h want 0", MemAddr); end
    n_vec++; if (MemWrData !== 24'd0) begin n_err++; $display("FAIL rst_memwrdata: got %h want 0", MemWrData); end
    n_vec++; if (MemWe !== 1'b0) begin n_err++; $display("FAIL rst_memwe: got %0b want 0", MemWe); end
    n_vec++; if (FifoLevel !== 3'd0) begin n_err++; $display("FAIL rst_level: got %0d want 0", FifoLevel); end
    n_vec++; if (StallCount !== 16'd0) begin n_err++; $display("FAIL rst_stall: got %0d want 0", StallCount); end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_vga_burst();
    logic exp_v;
    for (int i = 0; i < 14; i++) begin
      VidReq = (i < 10);
      VidAddr = 17'(i);
      tick();
      exp_v = (i >= 2 && i <= 11);
      n_vec++; if (VidValid !== exp_v) begin n_err++; $display("FAIL burst_valid[%0d]: got %0b want %0b", i, VidValid, exp_v); end
      if (exp_v) begin
        n_vec++; if (VidData !== 24'(i - 2)) begin n_err++; $display("FAIL burst_data[%0d]: got %h want %h", i, VidData, 24'(i - 2)); end
      end
      n_vec++; if (MemWe !== 1'b0) begin n_err++; $display("FAIL burst_memwe[%0d]: got %0b want 0", i, MemWe); end
    end
    VidReq = 1'b0;
    n_vec++; if (MemAddr !== 17'd9) begin n_err++; $display("FAIL burst_addr_hold: got %h want 9", MemAddr); end
  endtask

  task automatic test_single_write();
    VidReq = 1'b0; VBlank = 1'b1;
    WrReq = 1'b1; WrAddr = 17'd5; WrData = 24'hFF0000;
    #1;
    n_vec++; if (WrAck !== 1'b1) begin n_err++; $display("FAIL sw_wrack: got %0b want 1", WrAck); end
    tick();
    WrReq = 1'b0;
    n_vec++; if (FifoLevel !== 3'd1) begin n_err++; $display("FAIL sw_level1: got %0d want 1", FifoLevel); end
    n_vec++; if (MemWe !== 1'b0) begin n_err++; $display("FAIL sw_memwe_early: got %0b want 0", MemWe); end
    tick();
    n_vec++; if (MemWe !== 1'b1) begin n_err++; $display("FAIL sw_memwe: got %0b want 1", MemWe); end
    n_vec++; if (MemAddr !== 17'd5) begin n_err++; $display("FAIL sw_memaddr: got %h want 5", MemAddr); end
    n_vec++; if (MemWrData !== 24'hFF0000) begin n_err++; $display("FAIL sw_memwrdata: got %h want ff0000", MemWrData); end
    n_vec++; if (FifoLevel !== 3'd0) begin n_err++; $display("FAIL sw_level0: got %0d want 0", FifoLevel); end
    tick();
    n_vec++; if (MemWe !== 1'b0) begin n_err++; $display("FAIL sw_memwe_off: got %0b want 0", MemWe); end
    n_vec++; if (StallCount !== exp_stall) begin n_err++; $display("FAIL sw_stall: got %0d want %0d", StallCount, exp_stall); end
  endtask

  task automatic test_fifo_full();
    logic       exp_ack;
    logic [2:0] exp_lvl;
    int         idx = 0;
    VidReq = 1'b1; VidAddr = 17'd0;
    for (int c = 0; c < 7; c++) begin
      WrReq = 1'b1; WrAddr = 17'(16 + idx); WrData = 24'hA00000 + 24'(idx);
      #1;
      exp_ack = (c < 4);
      n_vec++; if (WrAck !== exp_ack) begin n_err++; $display("FAIL full_wrack[%0d]: got %0b want %0b", c, WrAck, exp_ack); end
      if (exp_ack) idx++;
      tick();
      exp_lvl = (c < 4) ? 3'(c + 1) : 3'd4;
      if (c >= 1) exp_stall = exp_stall + 16'd1;
      n_vec++; if (FifoLevel !== exp_lvl) begin n_err++; $display("FAIL full_level[%0d]: got %0d want %0d", c, FifoLevel, exp_lvl); end
      n_vec++; if (StallCount !== exp_stall) begin n_err++; $display("FAIL full_stall[%0d]: got %0d want %0d", c, StallCount, exp_stall); end
      n_vec++; if (MemWe !== 1'b0) begin n_err++; $display("FAIL full_memwe[%0d]: got %0b want 0", c, MemWe); end
    end
    WrReq = 1'b0;
  endtask

  task automatic test_push_pop_order();
    wr_entry_t  exp_e [5];
    logic [2:0] exp_lvl [5];
    exp_e[0] = '{addr: 17'd16, data: 24'hA00000}; exp_lvl[0] = 3'd3;
    exp_e[1] = '{addr: 17'd17, data: 24'hA00001}; exp_lvl[1] = 3'd2;
    exp_e[2] = '{addr: 17'd18, data: 24'hA00002}; exp_lvl[2] = 3'd2;
    exp_e[3] = '{addr: 17'd19, data: 24'hA00003}; exp_lvl[3] = 3'd1;
    exp_e[4] = '{addr: 17'd21, data: 24'hB00000}; exp_lvl[4] = 3'd0;
    VidReq = 1'b0;
    for (int j = 0; j < 5; j++) begin
      WrReq = (j == 2);
      if (j == 2) begin
        WrAddr = 17'd21; WrData = 24'hB00000;
        #1;
        n_vec++; if (WrAck !== 1'b1) begin n_err++; $display("FAIL pp_wrack: got %0b want 1", WrAck); end
      end
      tick();
      WrReq = 1'b0;
      n_vec++; if (MemWe !== 1'b1) begin n_err++; $display("FAIL pp_memwe[%0d]: got %0b want 1", j, MemWe); end
      n_vec++; if (MemAddr !== exp_e[j].addr) begin n_err++; $display("FAIL pp_addr[%0d]: got %h want %h", j, MemAddr, exp_e[j].addr); end
      n_vec++; if (MemWrData !== exp_e[j].data) begin n_err++; $display("FAIL pp_data[%0d]: got %h want %h", j, MemWrData, exp_e[j].data); end
      n_vec++; if (FifoLevel !== exp_lvl[j]) begin n_err++; $display("FAIL pp_level[%0d]: got %0d want %0d", j, FifoLevel, exp_lvl[j]); end
    end
    tick();
    n_vec++; if (MemWe !== 1'b0) begin n_err++; $display("FAIL pp_memwe_off: got %0b want 0", MemWe); end
    n_vec++; if (StallCount !== exp_stall) begin n_err++; $display("FAIL pp_stall: got %0d want %0d", StallCount, exp_stall); end
  endtask

  task automatic test_vblank_window();
    VidReq = 1'b0; VBlank = 1'b0;
    WrReq = 1'b1; WrAddr = 17'd30; WrData = 24'h123456;
    #1;
    n_vec++; if (WrAck !== 1'b1) begin n_err++; $display("FAIL vb_wrack: got %0b want 1", WrAck); end
    tick();
    WrReq = 1'b0;
`ifdef ARB_VBLANK_WRITES_EN
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_stall = exp_stall + 16'd1;
      n_vec++; if (MemWe !== 1'b0) begin n_err++; $display("FAIL vb_hold_memwe[%0d]: got %0b want 0", k, MemWe); end
      n_vec++; if (FifoLevel !== 3'd1) begin n_err++; $display("FAIL vb_hold_level[%0d]: got %0d want 1", k, FifoLevel); end
    end
    VBlank = 1'b1;
`endif
    tick();
    n_vec++; if (MemWe !== 1'b1) begin n_err++; $display("FAIL vb_memwe: got %0b want 1", MemWe); end
    n_vec++; if (MemAddr !== 17'd30) begin n_err++; $display("FAIL vb_memaddr: got %h want 1e", MemAddr); end
    n_vec++; if (FifoLevel !== 3'd0) begin n_err++; $display("FAIL vb_level: got %0d want 0", FifoLevel); end
    n_vec++; if (StallCount !== exp_stall) begin n_err++; $display("FAIL vb_stall: got %0d want %0d", StallCount, exp_stall); end
    VBlank = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    VidReq = 1'b1; VidAddr = 17'd7;
    for (int k = 0; k < 3; k++) begin
      WrReq = 1'b1; WrAddr = 17'(40 + k); WrData = 24'(k);
      tick();
    end
    n_vec++; if (FifoLevel !== 3'd3) begin n_err++; $display("FAIL rm_level3: got %0d want 3", FifoLevel); end
    n_vec++; if (VidValid !== 1'b1) begin n_err++; $display("FAIL rm_valid_pending: got %0b want 1", VidValid); end
    Reset = 1'b1;
    #1;
    n_vec++; if (WrAck !== 1'b0) begin n_err++; $display("FAIL rm_wrack: got %0b want 0", WrAck); end
    tick();
    n_vec++; if (VidData !== 24'd0) begin n_err++; $display("FAIL rm_viddata: got %h want 0", VidData); end
    n_vec++; if (VidValid !== 1'b0) begin n_err++; $display("FAIL rm_vidvalid: got %0b want 0", VidValid); end
    n_vec++; if (MemAddr !== 17'd0) begin n_err++; $display("FAIL rm_memaddr: got %h want 0", MemAddr); end
    n_vec++; if (MemWrData !== 24'd0) begin n_err++; $display("FAIL rm_memwrdata: got %h want 0", MemWrData); end
    n_vec++; if (MemWe !== 1'b0) begin n_err++; $display("FAIL rm_memwe: got %0b want 0", MemWe); end
    n_vec++; if (FifoLevel !== 3'd0) begin n_err++; $display("FAIL rm_level: got %0d want 0", FifoLevel); end
    n_vec++; if (StallCount !== 16'd0) begin n_err++; $display("FAIL rm_stall: got %0d want 0", StallCount); end
    Reset = 1'b0; VidReq = 1'b0; WrReq = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_vec++; if (VidValid !== 1'b0) begin n_err++; $display("FAIL rm_flush_valid[%0d]: got %0b want 0", k, VidValid); end
      n_vec++; if (MemWe !== 1'b0) begin n_err++; $display("FAIL rm_flush_memwe[%0d]: got %0b want 0", k, MemWe); end
    end
    VidReq = 1'b1; VidAddr = 17'd5;
    tick();
    VidReq = 1'b0;
    tick();
    tick();
    n_vec++; if (VidValid !== 1'b1) begin n_err++; $display("FAIL rm_read_valid: got %0b want 1", VidValid); end
    n_vec++; if (VidData !== 24'hFF0000) begin n_err++; $display("FAIL rm_read_data: got %h want ff0000", VidData); end
    tick();
    n_vec++; if (VidValid !== 1'b0) begin n_err++; $display("FAIL rm_read_done: got %0b want 0", VidValid); end
  endtask

  initial begin
    test_reset();
    test_vga_burst();
    test_single_write();
    test_fifo_full();
    test_push_pop_order();
    test_vblank_window();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
